// File: rtl/cpu_stack.sv
// rtl/cpu_stack.sv - parametrised accumulator CPU with CALL/RET stack, fetch stall and HALT.
// Optional JZ instruction on opcode 1010 enabled by macro CPU_STACK_JZ_EN.
module cpu_stack #(
  parameter int DATA_W      = 4,
  parameter int ADDR_W      = 4,
  parameter int STACK_DEPTH = 4,
  localparam int IMM_W      = (DATA_W > ADDR_W) ? DATA_W : ADDR_W,
  localparam int INSN_W     = 4 + IMM_W,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              n_reset,
  output logic [ADDR_W-1:0] addr,
  input  logic [INSN_W-1:0] data,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] switch,
  output logic [DATA_W-1:0] led,
  output logic              halted,
  output logic              stack_err
);

  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic              cf_q, cf_d, zf_q, zf_d;
  logic [ADDR_W-1:0] ip_q, ip_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              halted_q, halted_d, err_q, err_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];

  logic [3:0]        opcode;
  logic [DATA_W-1:0] imm_data;
  logic [ADDR_W-1:0] imm_addr;
  logic [ADDR_W-1:0] ip_next;
  logic [ADDR_W-1:0] stack_top;
  logic [DATA_W:0]   sum;

  assign opcode   = data[INSN_W-1 -: 4];
  assign imm_data = data[DATA_W-1:0];
  assign imm_addr = data[ADDR_W-1:0];
  assign ip_next  = ip_q + ADDR_W'(1);

`ifndef CPU_STACK_JZ_EN
  logic unused_zf;
  assign unused_zf = zf_q;
`endif

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    cf_d     = cf_q;
    zf_d     = zf_q;
    ip_d     = ip_q;
    sp_d     = sp_q;
    halted_d = halted_q;
    err_d    = err_q;
    sum      = '0;
    stack_d  = stack_q;

    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) stack_top = stack_q[i];
    end

    if (data_valid && !halted_q) begin
      ip_d = ip_next;
      cf_d = 1'b0;
      zf_d = 1'b0;
      case (opcode)
        4'b0000: begin
          sum        = {1'b0, a_q} + {1'b0, imm_data};
          {cf_d, a_d} = sum;
          zf_d       = (sum[DATA_W-1:0] == '0);
        end
        4'b0101: begin
          sum        = {1'b0, b_q} + {1'b0, imm_data};
          {cf_d, b_d} = sum;
          zf_d       = (sum[DATA_W-1:0] == '0);
        end
        4'b0011: a_d = imm_data;
        4'b0111: b_d = imm_data;
        4'b0001: a_d = b_q;
        4'b0100: b_d = a_q;
        4'b0010: a_d = switch;
        4'b0110: b_d = switch;
        4'b1001: out_d = b_q;
        4'b1011: out_d = imm_data;
        4'b1111: ip_d = imm_addr;
        4'b1110: if (!cf_q) ip_d = imm_addr;
`ifdef CPU_STACK_JZ_EN
        4'b1010: if (zf_q) ip_d = imm_addr;
`endif
        4'b1100: begin
          if (sp_q != SP_FULL) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
              if (sp_q == SP_W'(i)) stack_d[i] = ip_next;
            end
            sp_d = sp_q + SP_W'(1);
            ip_d = imm_addr;
          end else begin
            err_d    = 1'b1;
            halted_d = 1'b1;
            ip_d     = ip_q;
          end
        end
        4'b1101: begin
          if (sp_q != '0) begin
            sp_d = sp_q - SP_W'(1);
            ip_d = stack_top;
          end else begin
            err_d    = 1'b1;
            halted_d = 1'b1;
            ip_d     = ip_q;
          end
        end
        // HALT leaves addr pointing at itself
        4'b1000: begin
          halted_d = 1'b1;
          ip_d     = ip_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      ip_q     <= '0;
      sp_q     <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      cf_q     <= cf_d;
      zf_q     <= zf_d;
      ip_q     <= ip_d;
      sp_q     <= sp_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  // Return addresses need no reset: sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign addr      = ip_q;
  assign led       = out_q;
  assign halted    = halted_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_cpu_stack.sv
// tb/tb_cpu_stack.sv - bench for cpu_stack: vector table, corner sequences, random vs model.
module tb_cpu_stack;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [3:0] addr;
  logic [7:0] data;
  logic       data_valid;
  logic [3:0] switch_in;
  logic [3:0] led;
  logic       halted;
  logic       stack_err;

  logic [5:0]  addr2;
  logic [11:0] data2;
  logic        dv2;
  logic [7:0]  sw2;
  logic [7:0]  led2;
  logic        halted2;
  logic        err2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_stack dut (
    .clk(clk), .n_reset(n_reset), .addr(addr), .data(data), .data_valid(data_valid),
    .switch(switch_in), .led(led), .halted(halted), .stack_err(stack_err)
  );

  cpu_stack #(.DATA_W(8), .ADDR_W(6), .STACK_DEPTH(4)) dut_wide (
    .clk(clk), .n_reset(n_reset), .addr(addr2), .data(data2), .data_valid(dv2),
    .switch(sw2), .led(led2), .halted(halted2), .stack_err(err2)
  );

  typedef struct {
    logic       dv;
    logic [7:0] insn;
    logic [3:0] sw;
    logic [3:0] exp_addr;
    logic [3:0] exp_led;
    logic       exp_halt;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  int m_a, m_b, m_cf, m_zf, m_ip, m_out, m_h, m_e;
  int m_stk[$];

  function automatic void m_reset();
    m_a = 0; m_b = 0; m_cf = 0; m_zf = 0; m_ip = 0; m_out = 0; m_h = 0; m_e = 0;
    m_stk.delete();
  endfunction

  function automatic void m_step(input bit dv, input int d, input int sw);
    int op, imm, nip, s, ncf, nzf;
    if (!dv || m_h != 0) return;
    op  = (d >> 4) & 15;
    imm = d & 15;
    nip = (m_ip + 1) % 16;
    ncf = 0;
    nzf = 0;
    case (op)
      0:  begin s = m_a + imm; m_a = s % 16; ncf = s / 16; nzf = (m_a == 0); end
      5:  begin s = m_b + imm; m_b = s % 16; ncf = s / 16; nzf = (m_b == 0); end
      3:  m_a = imm;
      7:  m_b = imm;
      1:  m_a = m_b;
      4:  m_b = m_a;
      2:  m_a = sw;
      6:  m_b = sw;
      9:  m_out = m_b;
      11: m_out = imm;
      15: nip = imm;
      14: if (m_cf == 0) nip = imm;
`ifdef CPU_STACK_JZ_EN
      10: if (m_zf != 0) nip = imm;
`endif
      12: if (m_stk.size() < 4) begin m_stk.push_back(nip); nip = imm; end
          else begin m_e = 1; m_h = 1; nip = m_ip; end
      13: if (m_stk.size() > 0) nip = m_stk.pop_back();
          else begin m_e = 1; m_h = 1; nip = m_ip; end
      8:  begin m_h = 1; nip = m_ip; end
      default: ;
    endcase
    m_ip = nip; m_cf = ncf; m_zf = nzf;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    n_reset = 1'b0; data_valid = 1'b0; dv2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
    m_reset();
  endtask

  task automatic step(input logic dv, input logic [7:0] insn, input logic [3:0] sw);
    data_valid = dv; data = insn; switch_in = sw;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack(input int a, input int l, input int h, input int e);
    return {22'd0, a[3:0], l[3:0], h[0], e[0]};
  endfunction

  task automatic add_vec(input logic dv, input logic [7:0] insn, input logic [3:0] sw,
                         input logic [3:0] ea, input logic [3:0] el, input logic eh, input logic ee);
    vec_t v;
    v.dv = dv; v.insn = insn; v.sw = sw;
    v.exp_addr = ea; v.exp_led = el; v.exp_halt = eh; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  initial begin
    int held;
    n_reset = 1'b0; data = '0; data_valid = 1'b0; switch_in = '0;
    data2 = '0; dv2 = 1'b0; sw2 = '0;

    // Legacy program, stall, CALL/RET, wrap and RET underflow
    add_vec(1, 8'h33, 0, 1, 0, 0, 0);
    add_vec(1, 8'h0E, 0, 2, 0, 0, 0);
    add_vec(0, 8'hE5, 0, 2, 0, 0, 0);
    add_vec(0, 8'h00, 0, 2, 0, 0, 0);
    add_vec(0, 8'h80, 0, 2, 0, 0, 0);
    add_vec(1, 8'hE5, 0, 3, 0, 0, 0);
    add_vec(1, 8'hB7, 0, 4, 7, 0, 0);
    add_vec(1, 8'h10, 0, 5, 7, 0, 0);
    add_vec(1, 8'h26, 9, 6, 7, 0, 0);
    add_vec(1, 8'h40, 0, 7, 7, 0, 0);
    add_vec(1, 8'h90, 0, 8, 9, 0, 0);
    add_vec(1, 8'h57, 0, 9, 9, 0, 0);
    add_vec(1, 8'h90, 0, 10, 0, 0, 0);
    add_vec(1, 8'hE3, 0, 3, 0, 0, 0);
    add_vec(1, 8'h73, 0, 4, 0, 0, 0);
    add_vec(1, 8'hA7, 0, 5, 0, 0, 0);
    add_vec(1, 8'hC8, 0, 8, 0, 0, 0);
    add_vec(1, 8'hCC, 0, 12, 0, 0, 0);
    add_vec(1, 8'h9F, 0, 13, 3, 0, 0);
    add_vec(1, 8'hD0, 0, 9, 3, 0, 0);
    add_vec(1, 8'hD0, 0, 6, 3, 0, 0);
    add_vec(1, 8'h0F, 0, 7, 3, 0, 0);
    add_vec(1, 8'hE0, 0, 8, 3, 0, 0);
    add_vec(1, 8'hFF, 0, 15, 3, 0, 0);
    add_vec(1, 8'h40, 0, 0, 3, 0, 0);
    add_vec(1, 8'h90, 0, 1, 8, 0, 0);
    add_vec(1, 8'hD0, 0, 1, 8, 1, 1);
    add_vec(1, 8'hB5, 0, 1, 8, 1, 1);

    do_reset();
    check("reset_state", pack(addr, led, halted, stack_err), pack(0, 0, 0, 0));
    foreach (vecs[i]) begin
      step(vecs[i].dv, vecs[i].insn, vecs[i].sw);
      check($sformatf("vec%0d", i), pack(addr, led, halted, stack_err),
            pack(vecs[i].exp_addr, vecs[i].exp_led, vecs[i].exp_halt, vecs[i].exp_err));
    end

    // Five nested CALLs against a depth-4 stack
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step(1, 8'hC0 | 8'(i), 0);
      check($sformatf("call%0d", i), pack(addr, led, halted, stack_err), pack(i, 0, 0, 0));
    end
    step(1, 8'hC5, 0);
    check("call_overflow", pack(addr, led, halted, stack_err), pack(4, 0, 1, 1));
    step(1, 8'hD0, 0);
    check("overflow_sticky", pack(addr, led, halted, stack_err), pack(4, 0, 1, 1));

    // HALT holds addr, then asynchronous reset between edges
    do_reset();
    step(1, 8'hB6, 0);
    for (int i = 0; i < 4; i++) step(1, 8'hA0, 0);
    step(1, 8'h80, 0);
    check("halt_enter", pack(addr, led, halted, stack_err), pack(5, 6, 1, 0));
    for (int i = 0; i < 10; i++) step(1, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
    check("halt_hold", pack(addr, led, halted, stack_err), pack(5, 6, 1, 0));
    data_valid = 1'b0;
    @(negedge clk);
    #1 n_reset = 1'b0;
    #1 check("async_reset", pack(addr, led, halted, stack_err), pack(0, 0, 0, 0));
    #1 n_reset = 1'b1;
    m_reset();
    @(posedge clk);
    #1 check("post_reset_idle", pack(addr, led, halted, stack_err), pack(0, 0, 0, 0));

    // Wide data path / address configuration
    dv2 = 1'b1;
    data2 = 12'h3FF; @(posedge clk); #1;
    data2 = 12'h400; @(posedge clk); #1;
    data2 = 12'h900; @(posedge clk); #1;
    check("wide_led", {24'd0, led2}, 32'hFF);
    data2 = 12'h001; @(posedge clk); #1;
    data2 = 12'hA29; @(posedge clk); #1;
`ifdef CPU_STACK_JZ_EN
    check("wide_jz", {26'd0, addr2}, 32'd41);
`else
    check("wide_jz_nop", {26'd0, addr2}, 32'd5);
`endif
    data2 = 12'hF3F; @(posedge clk); #1;
    check("wide_jmp", {26'd0, addr2}, 32'd63);
    data2 = 12'h000; @(posedge clk); #1;
    check("wide_wrap", {26'd0, addr2}, 32'd0);
    dv2 = 1'b0;

    // Random instruction stream against the model
    do_reset();
    held = 0;
    for (int c = 0; c < 3000; c++) begin
      logic       dv;
      logic [7:0] d;
      logic [3:0] sw;
      if (m_h != 0 && held >= 3) begin
        do_reset();
        held = 0;
      end
      dv = ($urandom_range(0, 3) != 0);
      d  = 8'($urandom_range(0, 255));
      sw = 4'($urandom_range(0, 15));
      m_step(dv, d, sw);
      step(dv, d, sw);
      check($sformatf("rand%0d", c), pack(addr, led, halted, stack_err),
            pack(m_ip, m_out, m_h, m_e));
      if (m_h != 0) held++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
